// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types, constants and helpers for the 101 pattern transmitter
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic [2:0] MATCH_101 = 3'b101;

    // A requested length of 0, or one beyond the pattern register, means "use the full register".
    function automatic int eff_len(input int len, input int width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/pat_cnt_101.sv
// rtl/pat_cnt_101.sv - serial overlapping "101" counter with saturation and synchronous clear
//
// Ports:
//   clk    - clock
//   arst   - asynchronous active-low reset
//   clr_i  - clears history and count (takes priority over en_i)
//   en_i   - shift bit_i into the history this cycle
//   bit_i  - serial line bit
//   cnt_o  - saturating count of overlapping "101" occurrences
module pat_cnt_101
    import seq_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [2:0]       hist_q;
    logic [2:0]       hist_d;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    // Match on the history including this cycle's bit, so the count is final
    // one cycle after the last bit is on the line.
    always_comb begin
        hist_d = {hist_q[1:0], bit_i};
        hit    = en_i && (hist_d == MATCH_101);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            hist_q <= 3'b000;
            cnt_q  <= '0;
        end else if (clr_i) begin
            hist_q <= 3'b000;
            cnt_q  <= '0;
        end else if (en_i) begin
            hist_q <= hist_d;
            if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_gen_101.sv
// rtl/seq_gen_101.sv - serial pattern transmitter with repeats, idle gaps and a reference "101" counter
//
// Ports:
//   clk        - clock
//   arst       - asynchronous active-low reset
//   load_valid - load request
//   load_ready - high in IDLE; accept on load_valid && load_ready
//   load_data  - pattern, bit len-1 sent first
//   load_len   - pattern length (0 or > WIDTH means WIDTH)
//   load_rep   - extra repeats (total transmissions = load_rep + 1)
//   out        - serial line, 0 when not shifting
//   out_valid  - out carries a pattern bit
//   busy       - in SHIFT or GAP
//   done       - one-cycle pulse in the first IDLE cycle after the final bit
//   exp_cnt    - overlapping "101" occurrences emitted since the last accept
module seq_gen_101
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_rep,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_cnt
);

    localparam int GAP_W = $clog2(GAP + 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;     // pattern left-aligned so bit len-1 sits at the MSB
    logic [WIDTH-1:0] sh_q, sh_d;       // working shift register, MSB drives the line
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;   // bits remaining after the current one
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             done_q, done_d;
    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;

    assign len_eff = LEN_W'(eff_len(int'(load_len), WIDTH));
    assign aligned = load_data << (WIDTH - int'(len_eff));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        rep_d   = rep_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    accept  = 1'b1;
                    pat_d   = aligned;
                    sh_d    = aligned;
                    len_d   = len_eff;
                    bcnt_d  = len_eff - LEN_W'(1);
                    rep_d   = load_rep;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bcnt_q == '0) begin
                    if (rep_q != '0) begin
                        rep_d  = rep_q - CNT_W'(1);
                        sh_d   = pat_q;
                        bcnt_d = len_q - LEN_W'(1);
                        if (GAP == 0) begin
                            state_d = ST_SHIFT;
                        end else begin
                            gcnt_d  = GAP_W'(GAP - 1);
                            state_d = ST_GAP;
                        end
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sh_d   = sh_q << 1;
                    bcnt_d = bcnt_q - LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            rep_q   <= rep_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_SHIFT);
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign out        = out_valid && sh_q[WIDTH-1];
    assign done       = done_q;

    // Gap zeros go into the history too, so patterns only straddle repeats for small gaps.
    pat_cnt_101 #(
        .CNT_W (CNT_W)
    ) u_pat_cnt (
        .clk   (clk),
        .arst  (arst),
        .clr_i (accept),
        .en_i  (busy),
        .bit_i (out),
        .cnt_o (exp_cnt)
    );

endmodule

// File: tb/tb_seq_gen_101.sv
// tb/tb_seq_gen_101.sv - scoreboard bench for seq_gen_101
module tb_seq_gen_101;

    logic        clk;
    logic        arst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [4:0]  load_len;
    logic [7:0]  load_rep;
    logic        out;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [7:0]  exp_cnt;

    seq_gen_101 dut (
        .clk        (clk),
        .arst       (arst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .exp_cnt    (exp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic v;
    } line_t;

    typedef struct {
        int cycles;
        int cnt;
    } done_t;

    line_t line_q[$];
    done_t done_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // '1'/'0' are pattern bits with out_valid=1, '_' is a gap cycle (out=0, out_valid=0).
    task automatic push_line(input string s);
        line_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b = (s[i] == "1");
            e.v = (s[i] != "_");
            line_q.push_back(e);
        end
    endtask

    task automatic push_done(input int cycles, input int cnt);
        done_t d;
        d.cycles = cycles;
        d.cnt    = cnt;
        done_q.push_back(d);
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [7:0] r);
        @(posedge clk);
        #1;
        load_data  = d;
        load_len   = l;
        load_rep   = r;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        if (!done) begin
            chk({name, "_timeout"}, 32'(done), 32'd1);
        end
    endtask

    // Monitor: cycle 1 is the first negedge after the accepting edge.
    always @(negedge clk) begin
        line_t e;
        done_t d;
        if (arst) begin
            cyc++;
            if (busy) begin
                chk("ready_low_while_busy", 32'(load_ready), 32'd0);
                if (line_q.size() == 0) begin
                    chk("line_activity_expected", 32'(line_q.size() != 0), 32'd1);
                end else begin
                    e = line_q.pop_front();
                    chk("out", 32'(out), 32'(e.b));
                    chk("out_valid", 32'(out_valid), 32'(e.v));
                end
            end else begin
                chk("idle_line", {30'd0, out, out_valid}, 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cycles));
                    chk("exp_cnt_at_done", 32'(exp_cnt), 32'(d.cnt));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("ready_at_done", 32'(load_ready), 32'd1);
                end
            end
            if (load_valid && load_ready) begin
                cyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        arst       = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_rep   = '0;

        // Reset held with clock running
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_exp_cnt", 32'(exp_cnt), 32'd0);
        @(posedge clk);
        #2;
        arst = 1'b1;

        // Single frame: 10101
        push_line("10101");
        push_done(6, 2);
        send(16'h0015, 5'd5, 8'd0);
        wait_done("single");
        @(negedge clk);
        chk("exp_cnt_hold", 32'(exp_cnt), 32'd2);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Repeats with GAP=2
        push_line("101__101__101");
        push_done(14, 3);
        send(16'h0005, 5'd3, 8'd2);
        wait_done("repeat");

        // Length clamp: 0 and 20 both mean 16
        push_line("1111111111111111");
        push_done(17, 0);
        send(16'hFFFF, 5'd0, 8'd0);
        wait_done("clamp_len0");
        push_line("1111111111111111");
        push_done(17, 0);
        send(16'hFFFF, 5'd20, 8'd0);
        wait_done("clamp_len20");

        // Asynchronous reset after two bits, no done pulse
        push_line("10");
        send(16'h0005, 5'd3, 8'd2);
        @(negedge clk);
        @(negedge clk);
        #2;
        arst = 1'b0;
        #1;
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_load_ready", 32'(load_ready), 32'd1);
        chk("mid_rst_exp_cnt", 32'(exp_cnt), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        arst = 1'b1;
        push_line("101__101__101");
        push_done(14, 3);
        send(16'h0005, 5'd3, 8'd2);
        wait_done("rerun");

        // Busy rejection and back-to-back accept in the done cycle
        push_line("101__101__101");
        push_done(14, 3);
        push_line("10101");
        push_done(6, 2);
        @(posedge clk);
        #1;
        load_data  = 16'h0005;
        load_len   = 5'd3;
        load_rep   = 8'd2;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_data  = 16'h0015;
        load_len   = 5'd5;
        load_rep   = 8'd0;
        wait_done("b2b_first");
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_done("b2b_second");
        @(negedge clk);
        chk("b2b_exp_cnt", 32'(exp_cnt), 32'd2);

        repeat (3) @(negedge clk);
        chk("line_q_drained", 32'(line_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen_101.md
Name: seq_gen_101

Overview:
- Serial pattern transmitter: the driving end of the single-bit "101" detector line.
- Accepts a parallel word over a valid/ready load handshake, then shifts it out MSB-first, one bit per clock, repeated a programmable number of times with idle gaps.
- A built-in reference counter tallies overlapping "101" occurrences on the emitted line, giving benches and self-test logic the expected detector hit count.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- LEN_W, 5, width of load_len; must hold WIDTH.
- CNT_W, 8, width of load_rep and exp_cnt.
- GAP, 2, idle (out=0) cycles between repeats; 0 allowed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- arst  in  1  asynchronous, active-low reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE.
- load_data  in  WIDTH  pattern; bit len-1 is sent first.
- load_len  in  LEN_W  number of bits; 0 or >WIDTH is treated as WIDTH.
- load_rep  in  CNT_W  extra repeats; total transmissions = load_rep+1.
- out  out  1  serial line; 0 when not shifting.
- out_valid  out  1  high while out carries a pattern bit (not in gap or idle).
- busy  out  1  high in SHIFT or GAP.
- done  out  1  one-cycle pulse after the last bit of the last repeat.
- exp_cnt  out  CNT_W  count of overlapping "101" occurrences emitted since the last accept; saturates at all-ones.

Behaviour:
- Reset: arst low forces all outputs immediately, asynchronously: out=0, out_valid=0, busy=0, done=0, load_ready=1, exp_cnt=0, FSM=IDLE, history=000. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1.
  - Accept occurs on the edge where load_valid&&load_ready; it latches data, effective len and rep, clears exp_cnt and history, and moves to SHIFT.
- SHIFT:
  - The first bit appears on out the cycle after accept. Each bit is held exactly one cycle with out_valid=1, MSB (bit len-1) first.
  - After the last bit: if the repeat counter is nonzero, decrement it and go to GAP (or to SHIFT directly when GAP=0). Otherwise go to IDLE.
- GAP: out=0, out_valid=0, busy=1 for exactly GAP cycles, then SHIFT restarts from bit len-1 of the latched data.
- done:
  - Asserted in the first IDLE cycle after the final bit; busy=0 in that cycle.
  - load_ready=1 in that same cycle, so a new load may be accepted then (back-to-back).
- load_valid while busy is ignored; data is not captured.
- exp_cnt:
  - 3-bit history shifts in out every cycle while busy. Gap zeros are included, so a pattern can complete across a repeat boundary only when GAP=0 or GAP=1.
  - Increments when history==101. It is registered, so it reflects out up to the previous cycle.
  - The final value is valid in the done cycle and holds until the next accept.
  - Saturates at 2^CNT_W-1 and never wraps.
- Total cycles from accept to done: len*(rep+1) + GAP*rep + 1.

Decomposition:
- Package seq_gen_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the constant 3'b101 match value;
  - a function for the effective length clamp.
- One sub-module, pat_cnt_101: serial 3-bit history plus saturating counter with a clear input. It is reusable as a golden model in detector benches.

Test Plan:
- Reset: hold arst=0 with clk running → out=0, out_valid=0, busy=0, done=0, load_ready=1, exp_cnt=0. Assert arst asynchronously between edges → outputs clear without waiting for a clock edge.
- Single frame: load_data=16'h0015, len=5, rep=0 → out=1,0,1,0,1 on cycles 1–5 after accept, out_valid=1 on those cycles, done on cycle 6, exp_cnt=2.
- Repeats with default GAP=2: data=16'h0005, len=3, rep=2 → line 1,0,1,0,0,1,0,1,0,0,1,0,1 (out_valid=0 in gaps), done on cycle 14, exp_cnt=3.
- Length clamp: len=0, data=16'hFFFF, rep=0 → 16 ones, done on cycle 17, exp_cnt=0. Repeat with len=20 → identical result.
- Reset mid-shift: arst low after 2 bits of test 2 → immediate reset values, no done pulse. After release, test 2 reruns correctly.
- Busy rejection and back-to-back:
  - Hold load_valid=1 with data=16'h0015 (len=5) throughout test 2.
  - load_ready stays 0 during busy, so nothing is captured mid-frame.
  - The second accept happens in the done cycle; next bits follow on the following cycle.
  - The second frame ends with exp_cnt=2.
